wca_reg_readback16: RTL and testbench



---
 rtl/wca_reg_readback16.sv | 149 ++++++++++++++
 tb/tb_wca_reg_readback16.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wca_reg_readback16.sv
// Burst read-back of a flat 16-bit register bank over a valid/ready stream with a last marker.
// Optional macro WCA_REGRDBK_SNAPSHOT_EN captures the whole bank at request accept so a burst is coherent.
module wca_reg_readback16 #(
    parameter int NREGS = 16,
    parameter int AW    = 6
) (
    input  logic                  Clock,
    input  logic                  Aclr,
    input  logic [NREGS*16-1:0]   RegBank,
    input  logic                  ReqStart,
    input  logic [AW-1:0]         ReqAddr,
    input  logic [AW-1:0]         ReqCount,
    output logic                  ReqBusy,
    output logic [15:0]           RdData,
    output logic                  RdValid,
    input  logic                  RdReady,
    output logic                  RdLast,
    output logic                  ReqError
);

    localparam int            IW       = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] addr, addr_n;
    logic [AW-1:0] remaining, remaining_n;
    logic [15:0]   data_n;
    logic          vld_n, last_n, busy_n, err_n;
    logic          accept;

    logic [NREGS*16-1:0] src_bank;
    logic [15:0]         src_words [NREGS];
    logic [15:0]         fetch_word;

`ifdef WCA_REGRDBK_SNAPSHOT_EN
    logic [NREGS*16-1:0] shadow;

    always_ff @(posedge Clock or posedge Aclr) begin
        if (Aclr) begin
            shadow <= '0;
        end else if (accept) begin
            shadow <= RegBank;
        end
    end

    assign src_bank = shadow;
`else
    assign src_bank = RegBank;
`endif

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            src_words[i] = src_bank[16*i +: 16];
        end
    end

    // addr is always kept below NREGS, so the low IW bits select the word
    assign fetch_word = src_words[addr[IW-1:0]];

    always_ff @(posedge Clock or posedge Aclr) begin
        if (Aclr) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        addr_n      = addr;
        remaining_n = remaining;
        data_n      = RdData;
        vld_n       = RdValid;
        last_n      = RdLast;
        busy_n      = ReqBusy;
        err_n       = 1'b0;
        accept      = 1'b0;

        case (state)
            IDLE: begin
                if (ReqStart) begin
                    if (ReqAddr <= LAST_IDX) begin
                        accept      = 1'b1;
                        addr_n      = ReqAddr;
                        remaining_n = ReqCount;
                        busy_n      = 1'b1;
                        state_n     = FETCH;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            FETCH: begin
                data_n  = fetch_word;
                last_n  = (remaining == '0);
                vld_n   = 1'b1;
                state_n = SEND;
            end
            SEND: begin
                if (RdReady) begin
                    vld_n = 1'b0;
                    if (RdLast) begin
                        last_n  = 1'b0;
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end else begin
                        // wrap to register 0 past the top of the bank; count still governs length
                        addr_n      = (addr == LAST_IDX) ? '0 : addr + AW'(1);
                        remaining_n = remaining - AW'(1);
                        state_n     = FETCH;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                vld_n   = 1'b0;
                last_n  = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Aclr) begin
        if (Aclr) begin
            addr      <= '0;
            remaining <= '0;
            RdData    <= 16'h0000;
            RdValid   <= 1'b0;
            RdLast    <= 1'b0;
            ReqBusy   <= 1'b0;
            ReqError  <= 1'b0;
        end else begin
            addr      <= addr_n;
            remaining <= remaining_n;
            RdData    <= data_n;
            RdValid   <= vld_n;
            RdLast    <= last_n;
            ReqBusy   <= busy_n;
            ReqError  <= err_n;
        end
    end

endmodule

// File: tb/tb_wca_reg_readback16.sv
// Self-checking bench for wca_reg_readback16: table-driven bursts, hand-written corner sequences, random bursts.
// Expected words come from a bank-indexing model: word i of a burst is bank[(addr+i) mod NREGS].
module tb_wca_reg_readback16;

    localparam int NREGS = 16;
    localparam int AW    = 6;

    logic                Clock;
    logic                Aclr;
    logic [NREGS*16-1:0] RegBank;
    logic                ReqStart;
    logic [AW-1:0]       ReqAddr;
    logic [AW-1:0]       ReqCount;
    logic                ReqBusy;
    logic [15:0]         RdData;
    logic                RdValid;
    logic                RdReady;
    logic                RdLast;
    logic                ReqError;

    logic [15:0] bank [NREGS];
    logic [15:0] snap [NREGS];
    logic [15:0] got_d [$];
    bit          got_l [$];

    int checks = 0;
    int errors = 0;

    wca_reg_readback16 #(.NREGS(NREGS), .AW(AW)) dut (
        .Clock   (Clock),
        .Aclr    (Aclr),
        .RegBank (RegBank),
        .ReqStart(ReqStart),
        .ReqAddr (ReqAddr),
        .ReqCount(ReqCount),
        .ReqBusy (ReqBusy),
        .RdData  (RdData),
        .RdValid (RdValid),
        .RdReady (RdReady),
        .RdLast  (RdLast),
        .ReqError(ReqError)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always_comb begin
        RegBank = '0;
        for (int i = 0; i < NREGS; i++) begin
            RegBank[16*i +: 16] = bank[i];
        end
    end

    typedef struct {
        int addr;
        int cnt;
        int mode;
        int poke;
        int exp_first;
        int exp_last;
        int exp_n;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_word(input int idx);
`ifdef WCA_REGRDBK_SNAPSHOT_EN
        return snap[idx % NREGS];
`else
        return bank[idx % NREGS];
`endif
    endfunction

    task automatic fill_bank_default();
        for (int i = 0; i < NREGS; i++) bank[i] = 16'hA000 + 16'(i);
    endtask

    task automatic req(input int a, input int c);
        @(posedge Clock); #1;
        ReqStart = 1'b1;
        ReqAddr  = AW'(a);
        ReqCount = AW'(c);
        @(posedge Clock); #1;
        ReqStart = 1'b0;
    endtask

    // mode 0: always ready; 1: stall first word 5 cycles; 2: random ready
    task automatic run_burst(input int a, input int c, input int mode, input int poke, input int wr5);
        int  t, first_t, last_hs_t, stalls, gap_bad, n, lim;
        bit  done, err_seen, prev_stall, prev_l;
        logic [15:0] prev_d;
        got_d.delete();
        got_l.delete();
        for (int i = 0; i < NREGS; i++) snap[i] = bank[i];
        req(a, c);
        if (wr5 != 0) bank[5] = 16'h1234;
        chk("busy_after_accept", 32'(ReqBusy), 1);
        t = 0; first_t = -1; last_hs_t = -1; stalls = 0; gap_bad = 0;
        done = 0; err_seen = 0; prev_stall = 0; prev_l = 0; prev_d = '0;
        while (!done && t < 1000) begin
            case (mode)
                1: begin
                    if (RdValid && got_d.size() == 0 && stalls < 5) begin
                        RdReady = 1'b0;
                        stalls++;
                    end else begin
                        RdReady = 1'b1;
                    end
                end
                2: RdReady = 1'($urandom_range(0, 1));
                default: RdReady = 1'b1;
            endcase
            ReqStart = (poke != 0) && (t == 2 || t == 4);
            if (poke != 0) ReqAddr = (t == 2) ? AW'(20) : AW'(1);
            @(negedge Clock);
            if (ReqError) err_seen = 1;
            if (prev_stall)
                chk("hold_under_backpressure", {13'h0, RdValid, RdLast, 1'b0, RdData},
                    {13'h0, 1'b1, prev_l, 1'b0, prev_d});
            if (RdValid && first_t < 0) first_t = t;
            if (RdValid && RdReady) begin
                got_d.push_back(RdData);
                got_l.push_back(RdLast);
                if (last_hs_t >= 0 && (t - last_hs_t) != 2 && mode == 0) gap_bad++;
                last_hs_t = t;
                if (RdLast) done = 1;
            end
            prev_stall = RdValid && !RdReady;
            prev_d     = RdData;
            prev_l     = RdLast;
            @(posedge Clock); #1;
            t++;
        end
        RdReady  = 1'b0;
        ReqStart = 1'b0;
        chk("burst_done", 32'(done), 1);
        chk("first_word_latency", 32'(first_t), 1);
        if (mode == 0) chk("one_word_per_2_cycles", 32'(gap_bad), 0);
        if (mode == 1) chk("stall_cycles", 32'(stalls), 5);
        if (poke != 0) chk("start_while_busy_no_error", 32'(err_seen), 0);
        chk("busy_clear_after_last", 32'(ReqBusy), 0);
        chk("valid_clear_after_last", 32'(RdValid), 0);
        n = c + 1;
        chk("word_count", 32'(got_d.size()), 32'(n));
        lim = (got_d.size() < n) ? got_d.size() : n;
        for (int i = 0; i < lim; i++) begin
            chk("burst_word", {16'(i), got_d[i]}, {16'(i), model_word(a + i)});
            chk("last_flag", {16'(i), 15'h0, got_l[i]}, {16'(i), 15'h0, 1'(i == n - 1)});
        end
    endtask

    initial begin
        int vcnt;
        Aclr     = 1'b1;
        ReqStart = 1'b0;
        ReqAddr  = '0;
        ReqCount = '0;
        RdReady  = 1'b0;
        fill_bank_default();

        repeat (3) @(posedge Clock);
        @(negedge Clock);
        chk("reset_busy", 32'(ReqBusy), 0);
        chk("reset_valid", 32'(RdValid), 0);
        chk("reset_last", 32'(RdLast), 0);
        chk("reset_error", 32'(ReqError), 0);
        chk("reset_data", 32'(RdData), 0);
        @(posedge Clock); #1;
        Aclr = 1'b0;

        vecs[0] = '{3,  0,  0, 0, 'hA003, 'hA003, 1};
        vecs[1] = '{14, 3,  0, 0, 'hA00E, 'hA001, 4};
        vecs[2] = '{2,  1,  1, 0, 'hA002, 'hA003, 2};
        vecs[3] = '{5,  2,  0, 1, 'hA005, 'hA007, 3};
        vecs[4] = '{0,  63, 2, 0, 'hA000, 'hA00F, 64};
        vecs[5] = '{15, 1,  2, 0, 'hA00F, 'hA000, 2};
        for (int v = 0; v < 6; v++) begin
            run_burst(vecs[v].addr, vecs[v].cnt, vecs[v].mode, vecs[v].poke, 0);
            chk("table_count", 32'(got_d.size()), 32'(vecs[v].exp_n));
            if (got_d.size() > 0) begin
                chk("table_first", 32'(got_d[0]), 32'(vecs[v].exp_first));
                chk("table_final", 32'(got_d[got_d.size()-1]), 32'(vecs[v].exp_last));
            end
        end

        // out-of-range request
        req(20, 0);
        chk("err_pulse", 32'(ReqError), 1);
        chk("err_no_busy", 32'(ReqBusy), 0);
        vcnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clock); #1;
            if (i == 0) chk("err_one_cycle", 32'(ReqError), 0);
            if (RdValid || ReqBusy) vcnt++;
        end
        chk("err_no_burst", 32'(vcnt), 0);

        // asynchronous clear while a word is waiting in SEND
        req(0, 7);
        RdReady = 1'b0;
        vcnt = 0;
        while (!RdValid && vcnt < 10) begin
            @(posedge Clock); #1;
            vcnt++;
        end
        chk("valid_before_aclr", 32'(RdValid), 1);
        #2;
        Aclr = 1'b1;
        #1;
        chk("aclr_busy", 32'(ReqBusy), 0);
        chk("aclr_valid", 32'(RdValid), 0);
        chk("aclr_last", 32'(RdLast), 0);
        chk("aclr_error", 32'(ReqError), 0);
        chk("aclr_data", 32'(RdData), 0);
        @(posedge Clock); #1;
        Aclr = 1'b0;
        run_burst(3, 0, 0, 0, 0);
        if (got_d.size() > 0) chk("post_aclr_word", 32'(got_d[0]), 'hA003);

        // register write landing after accept
        fill_bank_default();
        run_burst(4, 1, 0, 0, 1);
        if (got_d.size() > 1) begin
`ifdef WCA_REGRDBK_SNAPSHOT_EN
            chk("snapshot_word5", 32'(got_d[1]), 'hA005);
`else
            chk("live_word5", 32'(got_d[1]), 'h1234);
`endif
        end

        // randomized bursts against the model
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < NREGS; i++) bank[i] = 16'($urandom);
            run_burst(int'($urandom_range(0, NREGS - 1)), int'($urandom_range(0, 20)),
                      (r % 2 == 0) ? 2 : 0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
